// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lock_pkg
//  Purpose  : Shared types and constants for the serial digital-lock controller.
//             Holds the controller state encoding, the default parameter values
//             and the width helpers used to size counters.
//  Revision : 1.0  initial release
// ============================================================================
package lock_pkg;

  // Controller states, explicitly encoded on 3 bits.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    LOCKOUT = 3'd4
  } lock_state_t;

  localparam int          C_DEF_CODE_LEN    = 4;
  localparam logic [3:0]  C_DEF_CODE        = 4'b0110;
  localparam int          C_DEF_MAX_FAIL    = 3;
  localparam int          C_DEF_UNLOCK_CYC  = 8;
  localparam int          C_DEF_LOCKOUT_CYC = 16;
  localparam int          C_DEF_TIMEOUT_CYC = 32;

  // Bits needed to hold values 0..max_val (never less than 1).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lock_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : lock_ctrl_if
//  Purpose  : Code-entry / status bundle between the lock datapath and the
//             lock controller.
//  Signals  : bit_in, bit_valid          serial code entry (master -> slave)
//             prog_we, prog_code         code programming (LOCK_PROG_EN only)
//             unlocked, locked_out,
//             alarm, fail_cnt            controller status (slave -> master)
//  Macro    : LOCK_PROG_EN adds the programming signals.
//  Revision : 1.0  initial release
// ============================================================================
interface lock_ctrl_if
  import lock_pkg::*;
#(
  parameter int CODE_LEN = C_DEF_CODE_LEN,
  parameter int MAX_FAIL = C_DEF_MAX_FAIL
) ();

  localparam int FW = cnt_width(MAX_FAIL);

  logic                bit_in;
  logic                bit_valid;
`ifdef LOCK_PROG_EN
  logic                prog_we;
  logic [CODE_LEN-1:0] prog_code;
`endif
  logic                unlocked;
  logic                locked_out;
  logic                alarm;
  logic [FW-1:0]       fail_cnt;

`ifdef LOCK_PROG_EN
  modport master (output bit_in, bit_valid, prog_we, prog_code,
                  input  unlocked, locked_out, alarm, fail_cnt);
  modport slave  (input  bit_in, bit_valid, prog_we, prog_code,
                  output unlocked, locked_out, alarm, fail_cnt);
`else
  modport master (output bit_in, bit_valid,
                  input  unlocked, locked_out, alarm, fail_cnt);
  modport slave  (input  bit_in, bit_valid,
                  output unlocked, locked_out, alarm, fail_cnt);
`endif

endinterface
`default_nettype wire

// File: rtl/lock_timer.sv
`default_nettype none
// ============================================================================
//  Module   : lock_timer
//  Purpose  : Loadable down-counter shared by every timed controller state.
//             Load wins over counting; the count holds at zero.
//  Ports    : clk, reset (async, active-low)
//             i_load      load strobe
//             i_load_val  value loaded on i_load
//             o_zero      count is zero
//  Revision : 1.0  initial release
// ============================================================================
module lock_timer #(
  parameter int WIDTH = 6
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_load_val,
  output logic                  o_zero
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - c_one;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lock_ctrl
//  Purpose  : Serial digital-lock sequencer. Collects CODE_LEN serial bits
//             (first bit lands in the MSB), compares them with the stored
//             code, opens a timed unlock window on a match, counts consecutive
//             failures and enters a timed lockout with a one-cycle alarm once
//             MAX_FAIL failures accumulate. Partial entries are discarded after
//             TIMEOUT_CYC idle cycles.
//  Ports    : clk, reset (async, active-low)
//             bus  lock_ctrl_if.slave (entry inputs, status outputs)
//  Macro    : LOCK_PROG_EN - the code register becomes writable from
//             prog_we/prog_code during the unlock window; otherwise the
//             compare value is the constant DEFAULT_CODE.
//  Revision : 1.0  initial release
// ============================================================================
module lock_ctrl
  import lock_pkg::*;
#(
  parameter int                  CODE_LEN     = C_DEF_CODE_LEN,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE = CODE_LEN'(C_DEF_CODE),
  parameter int                  MAX_FAIL     = C_DEF_MAX_FAIL,
  parameter int                  UNLOCK_CYC   = C_DEF_UNLOCK_CYC,
  parameter int                  LOCKOUT_CYC  = C_DEF_LOCKOUT_CYC,
  parameter int                  TIMEOUT_CYC  = C_DEF_TIMEOUT_CYC
) (
  input  wire logic  clk,
  input  wire logic  reset,
  lock_ctrl_if.slave bus
);

  localparam int FW = cnt_width(MAX_FAIL);
  localparam int BW = cnt_width(CODE_LEN);
  localparam int TW = cnt_width(max3(UNLOCK_CYC, LOCKOUT_CYC, TIMEOUT_CYC));

  // The timer counts down to zero inclusive, so N cycles load N-1.
  localparam logic [TW-1:0] c_unlock_ld  = TW'(UNLOCK_CYC - 1);
  localparam logic [TW-1:0] c_lockout_ld = TW'(LOCKOUT_CYC - 1);
  localparam logic [TW-1:0] c_timeout_ld = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] c_last_bit   = BW'(CODE_LEN - 1);
  localparam logic [BW-1:0] c_bit_one    = BW'(1);
  localparam logic [FW-1:0] c_fail_last  = FW'(MAX_FAIL - 1);
  localparam logic [FW-1:0] c_fail_max   = FW'(MAX_FAIL);
  localparam logic [FW-1:0] c_fail_one   = FW'(1);

  lock_state_t         r_state;
  logic [CODE_LEN-1:0] r_shift;
  logic [BW-1:0]       r_bits;
  logic [FW-1:0]       r_fail;
  logic                r_unlocked;
  logic                r_locked;
  logic                r_alarm;

  logic [CODE_LEN-1:0] w_code;
  logic [CODE_LEN-1:0] w_shift_next;
  logic                w_accept;
  logic                w_match;
  logic                w_tmr_load;
  logic [TW-1:0]       w_tmr_val;
  logic                w_tmr_zero;

  generate
    if (CODE_LEN > 1) begin : g_shift_multi
      assign w_shift_next = {r_shift[CODE_LEN-2:0], bus.bit_in};
    end else begin : g_shift_single
      assign w_shift_next = bus.bit_in;
    end
  endgenerate

`ifdef LOCK_PROG_EN
  logic [CODE_LEN-1:0] r_code;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_code <= DEFAULT_CODE;
    end else if (r_state == OPEN && bus.prog_we) begin
      r_code <= bus.prog_code;
    end
  end

  assign w_code = r_code;
`else
  assign w_code = DEFAULT_CODE;
`endif

  assign w_accept = bus.bit_valid && (r_state == IDLE || r_state == COLLECT);
  assign w_match  = (r_shift == w_code);

  // Timer reload: every accepted bit restarts the entry timeout; leaving
  // CHECK arms the window for whichever timed state comes next. Other state
  // entries happen with the timer already at zero.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = c_timeout_ld;
    if (w_accept) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = c_timeout_ld;
    end else if (r_state == CHECK) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = w_match ? c_unlock_ld : c_lockout_ld;
    end
  end

  lock_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bits     <= '0;
      r_fail     <= '0;
      r_unlocked <= 1'b0;
      r_locked   <= 1'b0;
      r_alarm    <= 1'b0;
    end else begin
      r_alarm <= 1'b0;
      case (r_state)
        IDLE, COLLECT: begin
          if (bus.bit_valid) begin
            r_shift <= w_shift_next;
            if (r_bits == c_last_bit) begin
              r_bits  <= '0;
              r_state <= CHECK;
            end else begin
              r_bits  <= r_bits + c_bit_one;
              r_state <= COLLECT;
            end
          end else if (r_state == COLLECT && w_tmr_zero) begin
            // Idle too long: drop the partial entry, failure count untouched.
            r_bits  <= '0;
            r_state <= IDLE;
          end
        end
        CHECK: begin
          if (w_match) begin
            r_fail     <= '0;
            r_state    <= OPEN;
            r_unlocked <= 1'b1;
          end else if (r_fail == c_fail_last) begin
            r_fail   <= c_fail_max;
            r_state  <= LOCKOUT;
            r_locked <= 1'b1;
            r_alarm  <= 1'b1;
          end else begin
            r_fail  <= r_fail + c_fail_one;
            r_state <= IDLE;
          end
        end
        OPEN: begin
          if (w_tmr_zero) begin
            r_state    <= IDLE;
            r_unlocked <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (w_tmr_zero) begin
            r_state  <= IDLE;
            r_locked <= 1'b0;
            r_fail   <= '0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_bits     <= '0;
          r_unlocked <= 1'b0;
          r_locked   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.unlocked   = r_unlocked;
  assign bus.locked_out = r_locked;
  assign bus.alarm      = r_alarm;
  assign bus.fail_cnt   = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lock_ctrl
//  Purpose  : Self-checking bench for lock_ctrl: a fixed vector table, hand
//             sequences for lockout, timeout, reset and programming, then
//             random entry traffic checked against a queue-based model.
//  Macro    : LOCK_PROG_EN enables the code-programming sequence.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lock_ctrl;

  localparam int CL = 4;
  localparam int MF = 3;
  localparam int UC = 8;
  localparam int LC = 16;
  localparam int TC = 32;
`ifdef LOCK_PROG_EN
  localparam bit PROG = 1'b1;
`else
  localparam bit PROG = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lock_ctrl_if #(.CODE_LEN(CL), .MAX_FAIL(MF)) bus ();

  lock_ctrl #(
    .CODE_LEN     (CL),
    .DEFAULT_CODE (4'b0110),
    .MAX_FAIL     (MF),
    .UNLOCK_CYC   (UC),
    .LOCKOUT_CYC  (LC),
    .TIMEOUT_CYC  (TC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int n_alarm, n_locked, n_unl;

  // Reference model: received bits in a queue, remaining-cycle counters for
  // the two windows, a pending-compare flag and an idle-run counter.
  bit         m_q[$];
  int         m_open, m_lock, m_fails, m_idle;
  bit         m_check, m_alarm;
  logic [3:0] m_entry, m_code;

  typedef struct {
    bit v; bit b; bit unl; bit lck; bit alm; int fc;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit v, input bit b, input bit unl, input bit lck,
                     input bit alm, input int fc);
    vec_t r;
    r.v = v; r.b = b; r.unl = unl; r.lck = lck; r.alm = alm; r.fc = fc;
    tbl.push_back(r);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_open = 0; m_lock = 0; m_fails = 0; m_idle = 0;
    m_check = 0; m_alarm = 0; m_entry = '0; m_code = 4'b0110;
  endtask

  task automatic model_edge(input bit v, input bit b, input bit pwe,
                            input logic [3:0] pc);
    m_alarm = 0;
    if (m_check) begin
      m_check = 0;
      if (m_entry == m_code) begin
        m_open  = UC;
        m_fails = 0;
      end else begin
        m_fails++;
        if (m_fails == MF) begin
          m_lock  = LC;
          m_alarm = 1;
        end
      end
    end else if (m_open > 0) begin
      if (PROG && pwe) m_code = pc;
      m_open--;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fails = 0;
    end else if (v) begin
      m_q.push_back(b);
      m_idle = 0;
      if (m_q.size() == CL) begin
        m_entry = '0;
        foreach (m_q[k]) m_entry = {m_entry[2:0], m_q[k]};
        m_q.delete();
        m_check = 1;
      end
    end else if (m_q.size() > 0) begin
      m_idle++;
      if (m_idle == TC) begin
        m_q.delete();
        m_idle = 0;
      end
    end
  endtask

  task automatic drive(input bit v, input bit b, input bit pwe,
                       input logic [3:0] pc);
    bus.bit_valid = v;
    bus.bit_in    = b;
`ifdef LOCK_PROG_EN
    bus.prog_we   = pwe;
    bus.prog_code = pc;
`endif
  endtask

  task automatic step(input bit v, input bit b, input bit pwe,
                      input logic [3:0] pc);
    drive(v, b, pwe, pc);
    @(posedge clk);
    model_edge(v, b, pwe, pc);
    #1;
    chk("unlocked",   int'(bus.unlocked),   int'(m_open > 0));
    chk("locked_out", int'(bus.locked_out), int'(m_lock > 0));
    chk("alarm",      int'(bus.alarm),      int'(m_alarm));
    chk("fail_cnt",   int'(bus.fail_cnt),   m_fails);
    n_alarm  += int'(bus.alarm);
    n_locked += int'(bus.locked_out);
    n_unl    += int'(bus.unlocked);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic enter(input logic [3:0] c);
    for (int k = 3; k >= 0; k--) step(1'b1, c[k], 1'b0, 4'h0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    reset = 1'b0;
    #2;
    chk("rst_unlocked",   int'(bus.unlocked),   0);
    chk("rst_locked_out", int'(bus.locked_out), 0);
    chk("rst_alarm",      int'(bus.alarm),      0);
    chk("rst_fail_cnt",   int'(bus.fail_cnt),   0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int w;
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    model_reset();
    #1;
    do_reset();

    // ---- vector table: correct entry, bits dropped while open, wrong entry
    // issued in the first idle cycle after the window closes.
    add(1,0, 0,0,0,0); add(1,1, 0,0,0,0); add(1,1, 0,0,0,0); add(1,0, 0,0,0,0);
    add(0,0, 1,0,0,0); add(0,0, 1,0,0,0); add(1,1, 1,0,0,0); add(0,0, 1,0,0,0);
    add(1,0, 1,0,0,0); add(0,0, 1,0,0,0); add(0,0, 1,0,0,0); add(0,0, 1,0,0,0);
    add(0,0, 0,0,0,0);
    add(1,1, 0,0,0,0); add(1,1, 0,0,0,0); add(1,1, 0,0,0,0); add(1,1, 0,0,0,0);
    add(0,0, 0,0,0,1); add(0,0, 0,0,0,1);
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].b, 1'b0, 4'h0);
      @(posedge clk);
      model_edge(tbl[i].v, tbl[i].b, 1'b0, 4'h0);
      #1;
      chk($sformatf("tbl%0d_unlocked", i),   int'(bus.unlocked),   int'(tbl[i].unl));
      chk($sformatf("tbl%0d_locked_out", i), int'(bus.locked_out), int'(tbl[i].lck));
      chk($sformatf("tbl%0d_alarm", i),      int'(bus.alarm),      int'(tbl[i].alm));
      chk($sformatf("tbl%0d_fail_cnt", i),   int'(bus.fail_cnt),   tbl[i].fc);
    end

    // ---- three wrong entries -> lockout with a single alarm
    do_reset();
    n_alarm = 0; n_locked = 0; n_unl = 0;
    for (int k = 0; k < 3; k++) begin
      enter(4'hF);
      idle();
      chk("t2_fail_step", int'(bus.fail_cnt), k + 1);
    end
    repeat (20) idle();
    chk("t2_alarm_pulses", n_alarm, 1);
    chk("t2_lock_cycles",  n_locked, LC);
    chk("t2_fail_after",   int'(bus.fail_cnt), 0);

    // ---- correct code during lockout is dropped
    do_reset();
    repeat (3) begin enter(4'hF); idle(); end
    n_unl = 0;
    enter(4'b0110);
    w = 0;
    while (bus.locked_out && w < 40) begin idle(); w++; end
    chk("t3_lock_end", int'(bus.locked_out), 0);
    chk("t3_no_unlock", n_unl, 0);
    enter(4'b0110);
    idle();
    chk("t3_unlock_after", int'(bus.unlocked), 1);

    // ---- entry timeout and its boundary
    do_reset();
    enter(4'hF); idle();
    step(1,0,0,0); step(1,1,0,0);
    repeat (TC) idle();
    chk("t4_fail_kept", int'(bus.fail_cnt), 1);
    enter(4'b0110); idle();
    chk("t4_unlock", int'(bus.unlocked), 1);
    chk("t4_fail_clr", int'(bus.fail_cnt), 0);
    repeat (UC) idle();
    step(1,0,0,0); step(1,1,0,0);
    repeat (TC - 1) idle();
    step(1,1,0,0); step(1,0,0,0); idle();
    chk("t4_boundary_unlock", int'(bus.unlocked), 1);

    // ---- reset mid-open and mid-entry
    do_reset();
    enter(4'b0110); idle(); repeat (3) idle();
    do_reset();
    step(1,0,0,0); step(1,1,0,0);
    do_reset();
    enter(4'b0110); idle();
    chk("t5_unlock", int'(bus.unlocked), 1);

`ifdef LOCK_PROG_EN
    // ---- reprogram the code while open
    do_reset();
    enter(4'b0110); idle();
    step(1'b0, 1'b0, 1'b1, 4'b1010);
    repeat (UC) idle();
    enter(4'b0110); idle();
    chk("t6_old_rejected", int'(bus.unlocked), 0);
    chk("t6_fail", int'(bus.fail_cnt), 1);
    enter(4'b1010); idle();
    chk("t6_new_unlock", int'(bus.unlocked), 1);
`endif

    // ---- random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bit         v, b, pwe;
      logic [3:0] pc, cur;
      int         idx;
      if ($urandom_range(0, 99) == 0) begin
        repeat ($urandom_range(TC - 4, TC + 4)) idle();
      end
      v   = ($urandom_range(0, 2) != 0);
      cur = m_code;
      idx = 3 - m_q.size();
      b   = ($urandom_range(0, 3) != 0) ? cur[idx] : 1'($urandom_range(0, 1));
      pwe = ($urandom_range(0, 9) == 0);
      pc  = 4'($urandom_range(0, 15));
      step(v, b, pwe, pc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
